// File: rtl/mem_pkg.sv
// Shared definitions for the load/store request controller: FSM states,
// RV32I funct3 codes, LSU load-select codes and the peripheral address bit.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] LD_SEL_B  = 3'b000;
    localparam logic [2:0] LD_SEL_H  = 3'b001;
    localparam logic [2:0] LD_SEL_W  = 3'b010;
    localparam logic [2:0] LD_SEL_BU = 3'b011;
    localparam logic [2:0] LD_SEL_HU = 3'b100;

    localparam int PERIPH_BIT = 14;

    function automatic logic [2:0] ld_sel_of(input logic [2:0] f3);
        case (f3)
            F3_B:    return LD_SEL_B;
            F3_H:    return LD_SEL_H;
            F3_BU:   return LD_SEL_BU;
            F3_HU:   return LD_SEL_HU;
            default: return LD_SEL_W;
        endcase
    endfunction

    // Unsupported funct3 codes are rejected through the same path as misalignment.
    function automatic logic req_legal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
        case (f3)
            F3_B:    return 1'b1;
            F3_BU:   return !we;
            F3_H:    return !addr_lo[0];
            F3_HU:   return !we && !addr_lo[0];
            F3_W:    return addr_lo == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/st_align.sv
// Store lane alignment: byte mask and lane-shifted write data from funct3
// and the low address bits. Purely combinational.
module st_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  bmask,
    output logic [31:0] wdata_al
);

    always_comb begin
        bmask    = 4'b1111;
        wdata_al = wdata;
        case (funct3)
            F3_B, F3_BU: begin
                bmask    = 4'b0001 << addr_lo;
                wdata_al = {24'd0, wdata[7:0]} << {addr_lo, 3'b000};
            end
            F3_H, F3_HU: begin
                bmask    = 4'b0011 << addr_lo;
                wdata_al = {16'd0, wdata[15:0]} << {addr_lo, 3'b000};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Load/store request controller between the core and the LSU (IDLE/ACCESS/DONE).
// Optional watchdog: define MEM_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [15:0] lsu_addr,
    output logic [31:0] lsu_wdata,
    output logic        lsu_wr_en,
    output logic        lsu_rd_en,
    output logic [3:0]  lsu_bmask,
    output logic [2:0]  lsu_ld_sel,
    input  logic [31:0] lsu_rdata,
    input  logic        lsu_ack,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        misalign,
    output logic        timeout
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_bad_timeout_cyc
        $error("TIMEOUT_CYC must fit the 8-bit watchdog counter");
    end

    state_t      state_q, state_d;
    logic        we_q;
    logic        legal;
    logic        accept;
    logic        done_acc;
    logic        to_hit;
    logic [3:0]  st_bmask;
    logic [31:0] st_wdata;

    st_align u_st_align (
        .funct3   (req_funct3),
        .addr_lo  (req_addr[1:0]),
        .wdata    (req_wdata),
        .bmask    (st_bmask),
        .wdata_al (st_wdata)
    );

    assign legal  = req_legal(req_we, req_funct3, req_addr[1:0]);
    assign accept = (state_q == IDLE) && req_valid && legal;

    // Peripherals answer in one cycle, so their ACCESS never waits for ack.
    assign done_acc = lsu_addr[PERIPH_BIT] || lsu_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        misalign = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (legal) begin
                        state_d = ACCESS;
                        stall   = 1'b1;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (done_acc)    state_d = DONE;
                else if (to_hit) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign lsu_rd_en = (state_q == ACCESS) && !we_q;
    assign lsu_wr_en = (state_q == ACCESS) && we_q;
    assign ld_valid  = (state_q == DONE) && !we_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q       <= 1'b0;
            lsu_addr   <= '0;
            lsu_wdata  <= '0;
            lsu_bmask  <= '0;
            lsu_ld_sel <= LD_SEL_W;
            ld_data    <= '0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                lsu_addr   <= req_addr;
                lsu_wdata  <= st_wdata;
                lsu_bmask  <= req_we ? st_bmask : 4'b1111;
                lsu_ld_sel <= ld_sel_of(req_funct3);
            end
            if (state_q == ACCESS && done_acc && !we_q) ld_data <= lsu_rdata;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] to_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   to_cnt_q <= '0;
        else if (state_q == ACCESS) to_cnt_q <= to_cnt_q + 8'd1;
        else                        to_cnt_q <= '0;
    end

    // Fires on the TIMEOUT_CYC-th ACCESS cycle; a same-cycle ack wins.
    assign to_hit = (state_q == ACCESS) && !done_acc && (to_cnt_q == 8'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    assign timeout = to_hit;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed scoreboard bench for mem_req_ctrl (default TIMEOUT_CYC; watchdog case under MEM_TIMEOUT_EN).
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [15:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_wr_en, lsu_rd_en;
    logic [3:0]  lsu_bmask;
    logic [2:0]  lsu_ld_sel;
    logic [31:0] lsu_rdata;
    logic        lsu_ack;
    logic        stall, ld_valid, misalign, timeout;
    logic [31:0] ld_data;

    always #5 clk = ~clk;

    mem_req_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_wr_en  (lsu_wr_en),
        .lsu_rd_en  (lsu_rd_en),
        .lsu_bmask  (lsu_bmask),
        .lsu_ld_sel (lsu_ld_sel),
        .lsu_rdata  (lsu_rdata),
        .lsu_ack    (lsu_ack),
        .stall      (stall),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .misalign   (misalign),
        .timeout    (timeout)
    );

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic [2:0]  sel;
        logic        is_st;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [31:0] ld_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/stall"},    32'(stall),      0);
        chk({tag, "/rd_en"},    32'(lsu_rd_en),  0);
        chk({tag, "/wr_en"},    32'(lsu_wr_en),  0);
        chk({tag, "/ld_valid"}, 32'(ld_valid),   0);
        chk({tag, "/misalign"}, 32'(misalign),   0);
        chk({tag, "/timeout"},  32'(timeout),    0);
        chk({tag, "/ld_data"},  ld_data,         0);
        chk({tag, "/addr"},     32'(lsu_addr),   0);
        chk({tag, "/wdata"},    lsu_wdata,       0);
        chk({tag, "/bmask"},    32'(lsu_bmask),  0);
        chk({tag, "/ld_sel"},   32'(lsu_ld_sel), 32'h2);
    endtask

    // One accepted request: e_done is the cycle (request cycle = 0) in which DONE is expected.
    task automatic xact(input string tag, input logic rel_rst, input logic we, input logic [2:0] f3,
                        input logic [15:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int ack_c, input logic [3:0] e_bm, input logic [31:0] e_wd,
                        input logic [2:0] e_sel, input int e_done);
        cmd_t e, cur;
        int   stall_n = 0, en_n = 0, bad_en = 0, vld_n = 0, to_n = 0, done_c = -1;
        e.addr = addr; e.wdata = e_wd; e.bmask = e_bm; e.sel = e_sel; e.is_st = we;
        cur = e;
        tick();
        if (rel_rst) rst = 1'b1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        lsu_rdata = rd; lsu_ack = 1'b0;
        cmd_q.push_back(e);
        if (!we) ld_q.push_back(rd);
        for (int c = 0; c <= e_done + 1; c++) begin
            if (c > 0) begin
                tick();
                req_valid = 1'b0;
                lsu_ack   = (c == ack_c);
            end
            @(negedge clk);
            if (c == 0) chk({tag, "/stall_c0"}, 32'(stall), 1);
            stall_n += int'(stall);
            to_n    += int'(timeout);
            if (we ? lsu_wr_en : lsu_rd_en) begin
                en_n++;
                if (en_n == 1) begin
                    if (cmd_q.size() == 0) chk({tag, "/cmd_q_nonempty"}, 0, 1);
                    else cur = cmd_q.pop_front();
                end
                chk({tag, "/addr"},  32'(lsu_addr),  32'(cur.addr));
                chk({tag, "/bmask"}, 32'(lsu_bmask), 32'(cur.bmask));
                if (cur.is_st) chk({tag, "/wdata"},  lsu_wdata,        cur.wdata);
                else           chk({tag, "/ld_sel"}, 32'(lsu_ld_sel), 32'(cur.sel));
            end
            if (we ? lsu_rd_en : lsu_wr_en) bad_en++;
            if (ld_valid) begin
                vld_n++;
                if (ld_q.size() == 0) chk({tag, "/ld_valid_expected"}, 1, 0);
                else chk({tag, "/ld_data"}, ld_data, ld_q.pop_front());
            end
            if (c > 0 && !stall && done_c < 0) done_c = c;
        end
        lsu_ack = 1'b0;
        chk({tag, "/stall_cycles"}, stall_n, e_done);
        chk({tag, "/en_cycles"},    en_n,    e_done - 1);
        chk({tag, "/wrong_en"},     bad_en,  0);
        chk({tag, "/ld_valid_n"},   vld_n,   we ? 0 : 1);
        chk({tag, "/done_cycle"},   done_c,  e_done);
        chk({tag, "/timeout_n"},    to_n,    0);
        chk({tag, "/cmd_q_drained"}, cmd_q.size(), 0);
    endtask

    task automatic bad_req(input string tag, input logic we, input logic [2:0] f3, input logic [15:0] addr);
        tick();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk({tag, "/misalign"}, 32'(misalign), 1);
        chk({tag, "/stall"},    32'(stall),    0);
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk({tag, "/misalign_off"}, 32'(misalign), 0);
            chk({tag, "/stall_off"},    32'(stall),    0);
            chk({tag, "/no_en"},        32'(lsu_rd_en | lsu_wr_en), 0);
            if (c == 1) tick();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; lsu_rdata = '0; lsu_ack = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        chk_reset("reset");

        xact("sw_dmem",  1'b1, 1'b1, 3'b010, 16'h0100, 32'h1234_ABCD, 32'h0, 3, 4'b1111, 32'h1234_ABCD, 3'b000, 4);
        xact("sb_b3",    1'b0, 1'b1, 3'b000, 16'h0103, 32'h0000_00EF, 32'h0, 1, 4'b1000, 32'hEF00_0000, 3'b000, 2);
        xact("sb_b1",    1'b0, 1'b1, 3'b000, 16'h0101, 32'hAABB_CCEF, 32'h0, 2, 4'b0010, 32'h0000_EF00, 3'b000, 3);
        xact("lhu",      1'b0, 1'b0, 3'b101, 16'h0102, 32'h0, 32'h0000_BEEF, 2, 4'b1111, 32'h0, 3'b100, 3);
        xact("sh_h1",    1'b0, 1'b1, 3'b001, 16'h0102, 32'h1234_ABCD, 32'h5555_5555, 1, 4'b1100, 32'hABCD_0000, 3'b000, 2);
        chk("ld_data_hold", ld_data, 32'h0000_BEEF);
        xact("lw_periph", 1'b0, 1'b0, 3'b010, 16'h4000, 32'h0, 32'hCAFE_F00D, -1, 4'b1111, 32'h0, 3'b010, 2);
        xact("lb",       1'b0, 1'b0, 3'b000, 16'h0001, 32'h0, 32'h1122_3344, 1, 4'b1111, 32'h0, 3'b000, 2);
        xact("lh_slow",  1'b0, 1'b0, 3'b001, 16'h0006, 32'h0, 32'h8765_4321, 4, 4'b1111, 32'h0, 3'b001, 5);
        xact("lbu_periph", 1'b0, 1'b0, 3'b100, 16'h4003, 32'h0, 32'h0000_00A5, -1, 4'b1111, 32'h0, 3'b011, 2);
        xact("sw_periph", 1'b0, 1'b1, 3'b010, 16'h4010, 32'hDEAD_BEEF, 32'h0, -1, 4'b1111, 32'hDEAD_BEEF, 3'b000, 2);

        bad_req("mis_lw",  1'b0, 3'b010, 16'h0101);
        bad_req("mis_lh",  1'b0, 3'b001, 16'h0003);
        bad_req("mis_sw",  1'b1, 3'b010, 16'h0102);
        bad_req("ill_f3_3", 1'b0, 3'b011, 16'h0000);
        bad_req("ill_f3_7", 1'b0, 3'b111, 16'h0000);

        // ack outside ACCESS must not start or finish anything
        tick();
        lsu_ack = 1'b1;
        @(negedge clk);
        chk("idle_ack/stall", 32'(stall), 0);
        chk("idle_ack/en",    32'(lsu_rd_en | lsu_wr_en), 0);
        tick();
        lsu_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack/ld_valid", 32'(ld_valid), 0);
        xact("after_ack", 1'b0, 1'b0, 3'b010, 16'h0010, 32'h0, 32'h0BAD_F00D, 2, 4'b1111, 32'h0, 3'b010, 3);

        // reset in the second ACCESS cycle of a dmem load
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 16'h0200; lsu_rdata = 32'h7777_7777;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid/pre_rd_en", 32'(lsu_rd_en), 1);
        tick();
        #2 rst = 1'b0;
        #1;
        chk_reset("rst_mid");
        xact("post_rst", 1'b1, 1'b0, 3'b010, 16'h4008, 32'h0, 32'h0102_0304, -1, 4'b1111, 32'h0, 3'b010, 2);

`ifdef MEM_TIMEOUT_EN
        begin
            int to_c = -1, to_n = 0, vld_n = 0;
            tick();
            req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 16'h0300; lsu_ack = 1'b0;
            for (int c = 0; c <= 300; c++) begin
                if (c > 0) begin
                    tick();
                    req_valid = 1'b0;
                end
                @(negedge clk);
                if (timeout) begin
                    to_n++;
                    if (to_c < 0) to_c = c;
                end
                vld_n += int'(ld_valid);
                if (to_c >= 0 && c == to_c + 1) begin
                    chk("wdog/stall_after", 32'(stall), 0);
                    chk("wdog/rd_en_after", 32'(lsu_rd_en), 0);
                end
            end
            chk("wdog/cycle",    to_c,  255);
            chk("wdog/pulses",   to_n,  1);
            chk("wdog/ld_valid", vld_n, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
